// File: rtl/pit_pkg.sv
// Shared encodings for the programmable interval timer channel: modes,
// channel states and the default counting-element width.
package pit_pkg;

    localparam int PIT_DEFAULT_WIDTH = 16;

    localparam logic [2:0] MODE_INT_TC   = 3'd0;
    localparam logic [2:0] MODE_ONE_SHOT = 3'd1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        COUNTING = 2'd2
    } pit_state_e;

    // Only the two implemented modes are accepted by a control write.
    function automatic logic pit_mode_valid(input logic [2:0] mode);
        return (mode == MODE_INT_TC) || (mode == MODE_ONE_SHOT);
    endfunction

endpackage

// File: rtl/pit_counter_channel_if.sv
// Host-side bus of one timer channel: control/count writes, count clock,
// gate, latch/read-back and the channel status outputs.
interface pit_counter_channel_if;

    logic       CTRL_WR;
    logic [2:0] MODE;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       TICK;
    logic       GATE;
    logic       LATCH;
    logic       RD_EN;
    logic [7:0] RD_DATA;
    logic       OUT;
    logic       NULL_COUNT;

    modport master (
        output CTRL_WR, MODE, WR_EN, WR_DATA, TICK, GATE, LATCH, RD_EN,
        input  RD_DATA, OUT, NULL_COUNT
    );

    modport slave (
        input  CTRL_WR, MODE, WR_EN, WR_DATA, TICK, GATE, LATCH, RD_EN,
        output RD_DATA, OUT, NULL_COUNT
    );

endinterface

// File: rtl/pit_read_latch.sv
// Read-back path: output latch snapshot of the counting element and the
// LSB-first byte sequencer feeding the registered read data.
module pit_read_latch
    import pit_pkg::*;
#(
    parameter int WIDTH = PIT_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             latch,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] ce,
    output logic [7:0]       rd_data
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] ol_r;
    logic             latched_r;
    logic [1:0]       rd_ptr_r;
    logic [7:0]       rd_data_r;
    logic [WIDTH-1:0] src_s;
    logic [7:0]       byte_s;
    logic             rd_last_s;

    // Select the byte addressed by the read pointer from latch or live count.
    always_comb begin
        src_s     = latched_r ? ol_r : ce;
        rd_last_s = (rd_ptr_r == 2'(NBYTES - 1));
        byte_s    = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (rd_ptr_r == 2'(b)) begin
                byte_s = src_s[b*8 +: 8];
            end else begin
                byte_s = byte_s;
            end
        end
    end

    // Latch capture, read pointer advance and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ol_r      <= '0;
            latched_r <= 1'b0;
            rd_ptr_r  <= 2'd0;
            rd_data_r <= 8'h00;
        end else if (clr) begin
            latched_r <= 1'b0;
            rd_ptr_r  <= 2'd0;
        end else begin
            if (rd_en) begin
                rd_data_r <= byte_s;
                if (rd_last_s) begin
                    rd_ptr_r  <= 2'd0;
                    latched_r <= 1'b0;
                end else begin
                    rd_ptr_r <= rd_ptr_r + 2'd1;
                end
            end
            // An unread snapshot blocks further latch commands.
            if (latch && !latched_r) begin
                ol_r      <= ce;
                latched_r <= 1'b1;
            end
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/pit_counter_channel.sv
// One timer channel: count-register write sequencer, load/decrement control
// for interrupt-on-terminal-count and retriggerable one-shot, and OUT/NULL_COUNT.
module pit_counter_channel
    import pit_pkg::*;
#(
    parameter int WIDTH = PIT_DEFAULT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    pit_counter_channel_if.slave  bus
);

    localparam int NBYTES = WIDTH / 8;
    localparam logic [WIDTH-1:0] CE_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       mode_r;
    pit_state_e       state_r;
    logic [WIDTH-1:0] cr_r;
    logic [WIDTH-1:0] ce_r;
    logic [1:0]       wr_ptr_r;
    logic             prog_r;
    logic             out_r;
    logic             null_count_r;
    logic             gate_d_r;
    logic             trig_r;

    logic             ctrl_s;
    logic             wr_s;
    logic             wr_last_s;
    logic             gate_rise_s;
    logic             load_s;
    logic             dec_s;
    logic [WIDTH-1:0] ce_dec_s;
    logic [7:0]       rd_data_s;

    // Qualify strobes and decide whether this tick loads or decrements.
    always_comb begin
        ctrl_s      = bus.CTRL_WR && pit_mode_valid(bus.MODE);
        wr_s        = bus.WR_EN && prog_r && !ctrl_s;
        wr_last_s   = (wr_ptr_r == 2'(NBYTES - 1));
        gate_rise_s = bus.GATE && !gate_d_r;
        ce_dec_s    = ce_r - CE_ONE;
        load_s      = 1'b0;
        dec_s       = 1'b0;
        if (bus.TICK) begin
            if (mode_r == MODE_ONE_SHOT) begin
                if (trig_r && (state_r != IDLE)) begin
                    load_s = 1'b1;
                end else if (state_r == COUNTING) begin
                    dec_s = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end else begin
                if (state_r == ARMED) begin
                    load_s = 1'b1;
                end else if ((state_r == COUNTING) && bus.GATE) begin
                    dec_s = 1'b1;
                end else begin
                    dec_s = 1'b0;
                end
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Channel state, count registers, trigger and output flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_r       <= MODE_INT_TC;
            state_r      <= IDLE;
            cr_r         <= '0;
            ce_r         <= '0;
            wr_ptr_r     <= 2'd0;
            prog_r       <= 1'b0;
            out_r        <= 1'b0;
            null_count_r <= 1'b0;
            gate_d_r     <= 1'b0;
            trig_r       <= 1'b0;
        end else if (ctrl_s) begin
            mode_r       <= bus.MODE;
            state_r      <= IDLE;
            wr_ptr_r     <= 2'd0;
            prog_r       <= 1'b1;
            out_r        <= (bus.MODE == MODE_ONE_SHOT);
            null_count_r <= 1'b0;
            gate_d_r     <= bus.GATE;
            trig_r       <= 1'b0;
        end else begin
            gate_d_r <= bus.GATE;
            if (load_s) begin
                ce_r         <= cr_r;
                state_r      <= COUNTING;
                null_count_r <= 1'b0;
                trig_r       <= 1'b0;
                if (mode_r == MODE_ONE_SHOT) begin
                    out_r <= 1'b0;
                end
            end else if (dec_s) begin
                ce_r <= ce_dec_s;
                if (ce_dec_s == '0) begin
                    out_r <= 1'b1;
                end
            end
            if ((mode_r == MODE_ONE_SHOT) && gate_rise_s && (state_r != IDLE)) begin
                trig_r <= 1'b1;
            end
            // Write handling comes last so a count write overrides a same-cycle tick.
            if (wr_s) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (wr_ptr_r == 2'(b)) begin
                        cr_r[b*8 +: 8] <= bus.WR_DATA;
                    end
                end
                if ((mode_r == MODE_INT_TC) && (wr_ptr_r == 2'd0)) begin
                    out_r   <= 1'b0;
                    state_r <= IDLE;
                end
                if (wr_last_s) begin
                    wr_ptr_r     <= 2'd0;
                    null_count_r <= 1'b1;
                    if ((mode_r == MODE_INT_TC) || (state_r == IDLE)) begin
                        state_r <= ARMED;
                    end
                end else begin
                    wr_ptr_r <= wr_ptr_r + 2'd1;
                end
            end
        end
    end

    pit_read_latch #(
        .WIDTH (WIDTH)
    ) u_read_latch (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (ctrl_s),
        .latch   (bus.LATCH),
        .rd_en   (bus.RD_EN),
        .ce      (ce_r),
        .rd_data (rd_data_s)
    );

    assign bus.RD_DATA    = rd_data_s;
    assign bus.OUT        = out_r;
    assign bus.NULL_COUNT = null_count_r;

endmodule

// File: tb/tb_pit_counter_channel.sv
// Directed bench: a 16-bit channel for most scenarios plus an 8-bit channel
// sharing the same stimulus for the full-range (count 0) case.
module tb_pit_counter_channel;

    logic CLK;
    logic RST_N;
    int   n_tests;
    int   n_fail;

    pit_counter_channel_if b16 ();
    pit_counter_channel_if b8 ();

    assign b8.CTRL_WR = b16.CTRL_WR;
    assign b8.MODE    = b16.MODE;
    assign b8.WR_EN   = b16.WR_EN;
    assign b8.WR_DATA = b16.WR_DATA;
    assign b8.TICK    = b16.TICK;
    assign b8.GATE    = b16.GATE;
    assign b8.LATCH   = b16.LATCH;
    assign b8.RD_EN   = b16.RD_EN;

    pit_counter_channel #(.WIDTH(16)) dut16 (.CLK(CLK), .RST_N(RST_N), .bus(b16));
    pit_counter_channel #(.WIDTH(8))  dut8  (.CLK(CLK), .RST_N(RST_N), .bus(b8));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic ctrl(input logic [2:0] m);
        b16.CTRL_WR = 1'b1;
        b16.MODE    = m;
        cyc();
        b16.CTRL_WR = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d);
        b16.WR_EN   = 1'b1;
        b16.WR_DATA = d;
        cyc();
        b16.WR_EN   = 1'b0;
    endtask

    task automatic ticks(input int n);
        b16.TICK = 1'b1;
        repeat (n) cyc();
        b16.TICK = 1'b0;
    endtask

    task automatic rd(output logic [7:0] v);
        b16.RD_EN = 1'b1;
        cyc();
        b16.RD_EN = 1'b0;
        v = b16.RD_DATA;
    endtask

    task automatic rd_ce16(output logic [15:0] v);
        logic [7:0] lo;
        logic [7:0] hi;
        rd(lo);
        rd(hi);
        v = {hi, lo};
    endtask

    // Runs continuous ticks and counts samples with OUT low; optionally
    // re-raises GATE so the retrigger replaces the tick that would reach CE=2.
    task automatic measure_low(input bit retrig, output int n);
        bit done;
        done = 1'b0;
        n    = 0;
        b16.TICK = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            b16.GATE = retrig && (i == 1);
            cyc();
            if (b16.OUT === 1'b0) n++;
            else done = 1'b1;
        end
        b16.TICK = 1'b0;
        b16.GATE = 1'b0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] v;
        int          n;
        n_tests = 0;
        n_fail  = 0;
        b16.CTRL_WR = 1'b0; b16.MODE = 3'd0; b16.WR_EN = 1'b0; b16.WR_DATA = 8'h00;
        b16.TICK = 1'b0; b16.GATE = 1'b1; b16.LATCH = 1'b0; b16.RD_EN = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_out", 32'(b16.OUT), 32'd0);
        check_val("rst_null", 32'(b16.NULL_COUNT), 32'd0);
        check_val("rst_rd", 32'(b16.RD_DATA), 32'd0);
        RST_N = 1'b1;
        cyc();

        // Writes before any control word are ignored.
        wr(8'h05); wr(8'h00);
        check_val("noprog_null", 32'(b16.NULL_COUNT), 32'd0);
        ticks(3);
        rd_ce16(v);
        check_val("noprog_ce", 32'(v), 32'h0000);

        // Mode 0, count 5: OUT rises on the 6th tick after completion.
        ctrl(3'd0);
        check_val("m0_ctrl_out", 32'(b16.OUT), 32'd0);
        wr(8'h05);
        check_val("m0_null_partial", 32'(b16.NULL_COUNT), 32'd0);
        wr(8'h00);
        check_val("m0_null_set", 32'(b16.NULL_COUNT), 32'd1);
        ticks(1);
        check_val("m0_null_clr", 32'(b16.NULL_COUNT), 32'd0);
        ticks(4);
        check_val("m0_out_5", 32'(b16.OUT), 32'd0);
        rd_ce16(v);
        check_val("m0_ce_5", 32'(v), 32'h0001);
        ticks(1);
        check_val("m0_out_6", 32'(b16.OUT), 32'd1);
        ticks(2);
        rd_ce16(v);
        check_val("m0_wrap", 32'(v), 32'hFFFE);
        check_val("m0_out_hold", 32'(b16.OUT), 32'd1);

        // Illegal mode is ignored; first count byte forces OUT low and suspends.
        ctrl(3'd5);
        check_val("bad_mode_out", 32'(b16.OUT), 32'd1);
        wr(8'h0A);
        check_val("m0_first_byte_out", 32'(b16.OUT), 32'd0);
        ticks(2);
        rd_ce16(v);
        check_val("m0_suspend", 32'(v), 32'hFFFE);

        // Count 10 with GATE low for 3 ticks: OUT at 14 ticks instead of 11.
        wr(8'h00);
        ticks(5);
        b16.GATE = 1'b0;
        ticks(3);
        rd_ce16(v);
        check_val("gate_hold_ce", 32'(v), 32'h0006);
        b16.GATE = 1'b1;
        ticks(5);
        check_val("gate_out_13", 32'(b16.OUT), 32'd0);
        ticks(1);
        check_val("gate_out_14", 32'(b16.OUT), 32'd1);

        // Mode 1, count 4: trigger, then retrigger.
        b16.GATE = 1'b0;
        ctrl(3'd1);
        check_val("m1_ctrl_out", 32'(b16.OUT), 32'd1);
        wr(8'h04); wr(8'h00);
        ticks(2);
        check_val("m1_no_trig_out", 32'(b16.OUT), 32'd1);
        check_val("m1_no_trig_null", 32'(b16.NULL_COUNT), 32'd1);
        b16.GATE = 1'b1; b16.TICK = 1'b1;
        cyc();
        check_val("m1_trig_reg_out", 32'(b16.OUT), 32'd1);
        measure_low(1'b0, n);
        check_val("m1_low_ticks", 32'(n), 32'd4);
        check_val("m1_null_clr", 32'(b16.NULL_COUNT), 32'd0);
        b16.GATE = 1'b1; b16.TICK = 1'b1;
        cyc();
        measure_low(1'b1, n);
        check_val("m1_retrig_low", 32'(n), 32'd6);

        // Latch at CE=0x1200 coinciding with a tick, a second ignored latch, reads.
        b16.GATE = 1'b1;
        ctrl(3'd0);
        wr(8'h34); wr(8'h12);
        ticks(1 + 8'h34);
        b16.LATCH = 1'b1; b16.TICK = 1'b1;
        cyc();
        b16.LATCH = 1'b0;
        ticks(1);
        b16.LATCH = 1'b1;
        cyc();
        b16.LATCH = 1'b0;
        rd(b); check_val("latch_lsb", 32'(b), 32'h00);
        rd(b); check_val("latch_msb", 32'(b), 32'h12);
        rd(b); check_val("live_lsb", 32'(b), 32'hFE);
        rd(b); check_val("live_msb", 32'(b), 32'h11);

        // Reset mid-count at CE=3 aborts the count immediately.
        ctrl(3'd0);
        wr(8'h0A); wr(8'h00);
        ticks(8);
        rd(b); check_val("pre_rst_ce", 32'(b), 32'h03);
        #2 RST_N = 1'b0;
        #1;
        check_val("async_rst_rd", 32'(b16.RD_DATA), 32'd0);
        check_val("async_rst_out", 32'(b16.OUT), 32'd0);
        check_val("async_rst_null", 32'(b16.NULL_COUNT), 32'd0);
        #3 RST_N = 1'b1;
        ticks(20);
        check_val("post_rst_out", 32'(b16.OUT), 32'd0);
        rd_ce16(v);
        check_val("post_rst_ce", 32'(v), 32'h0000);

        // CTRL_WR colliding with WR_EN discards the byte.
        b16.CTRL_WR = 1'b1; b16.MODE = 3'd0; b16.WR_EN = 1'b1; b16.WR_DATA = 8'hAA;
        cyc();
        b16.CTRL_WR = 1'b0; b16.WR_EN = 1'b0;
        wr(8'h03);
        check_val("collide_null_1", 32'(b16.NULL_COUNT), 32'd0);
        wr(8'h00);
        check_val("collide_null_2", 32'(b16.NULL_COUNT), 32'd1);
        ticks(3);
        check_val("collide_out_3", 32'(b16.OUT), 32'd0);
        ticks(1);
        check_val("collide_out_4", 32'(b16.OUT), 32'd1);

        // WIDTH=8, count 0 means 256 counting ticks after the load tick.
        ctrl(3'd0);
        wr(8'h00);
        check_val("w8_null", 32'(b8.NULL_COUNT), 32'd1);
        ticks(1);
        check_val("w8_load_out", 32'(b8.OUT), 32'd0);
        ticks(255);
        check_val("w8_out_255", 32'(b8.OUT), 32'd0);
        ticks(1);
        check_val("w8_out_256", 32'(b8.OUT), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pit_counter_channel.md
PIT_COUNTER_CHANNEL -- requirements
Module: pit_counter_channel

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, counting-element width in bits; legal values 8, 16, 24 or 32.
REQ-002 SHALL derive localparam NBYTES = WIDTH/8, the number of bytes per count write and per read.
REQ-003 SHALL have port CLK, input, 1, single system clock; all logic on posedge.
REQ-004 SHALL have port RST_N, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port CTRL_WR, input, 1, control-word strobe for this channel; samples MODE.
REQ-006 SHALL have port MODE, input, 3, operating mode; 3'd0 = interrupt on terminal count, 3'd1 = retriggerable one-shot; other values ignored (CTRL_WR has no effect).
REQ-007 SHALL have port WR_EN, input, 1, count-byte write strobe.
REQ-008 SHALL have port WR_DATA, input, 8, count byte, LSB first.
REQ-009 SHALL have port TICK, input, 1, one-CLK-wide count-clock enable.
REQ-010 SHALL have port GATE, input, 1, gate input.
REQ-011 SHALL have port LATCH, input, 1, counter-latch command.
REQ-012 SHALL have port RD_EN, input, 1, read strobe.
REQ-013 SHALL have port RD_DATA, output, 8, read byte, registered.
REQ-014 SHALL have port OUT, output, 1, channel output, registered.
REQ-015 SHALL have port NULL_COUNT, output, 1, high from count-write completion until that count is loaded into the counting element (CE).

Function
REQ-016 CTRL_WR SHALL store MODE, clear the byte sequencer, clear the latch, enter state IDLE, and set OUT to 0 (mode 0) or 1 (mode 1).
REQ-017 Write sequencer SHALL assemble NBYTES writes LSB first into the count register CR; completion sets NULL_COUNT=1.
REQ-018 Mode 0: writing the first byte SHALL force OUT=0 and suspend decrementing until the count is complete.
REQ-019 State machine SHALL be IDLE -> ARMED (CR complete) -> COUNTING.
REQ-020 Mode 0 load: first TICK in ARMED SHALL copy CR to CE, clear NULL_COUNT, and go to COUNTING; no decrement on the load tick.
REQ-021 Mode 0 count: each TICK in COUNTING with GATE=1 SHALL decrement CE; with GATE=0, CE SHALL hold.
REQ-022 Mode 0 terminal: when CE reaches 0, OUT SHALL go 1 on the same cycle's register update and stay 1 until the next CTRL_WR or first count byte; CE SHALL keep wrapping (0 -> all ones).
REQ-023 Mode 1 trigger: a GATE rising edge, registered one cycle, SHALL arm the trigger; the next TICK SHALL load CR into CE, set OUT=0, and clear NULL_COUNT.
REQ-024 Mode 1 count: subsequent TICKs SHALL decrement regardless of GATE level; OUT SHALL go 1 when CE reaches 0.
REQ-025 Mode 1 retrigger: a retrigger while COUNTING SHALL reload CR on the next TICK with OUT held 0; a new CR affects only the next trigger.
REQ-026 CR = 0 SHALL mean 2^WIDTH ticks.
REQ-027 LATCH SHALL snapshot CE into OL; a LATCH while OL is unread SHALL be ignored.
REQ-028 Reads SHALL return OL bytes LSB first, or live CE bytes if nothing is latched; after NBYTES reads the latch SHALL release and the pointer return to LSB.
REQ-029 RD_DATA SHALL be valid the cycle after RD_EN.
REQ-030 CTRL_WR SHALL win over simultaneous WR_EN, LATCH, or TICK in the same cycle.
REQ-031 A LATCH coinciding with a TICK SHALL capture the pre-decrement CE value.

Reset
REQ-032 RST_N low SHALL immediately set mode=0, state IDLE, CR=CE=OL=0, sequencers cleared, OUT=0, NULL_COUNT=0, RD_DATA=0.
REQ-033 Reset asserted mid-count SHALL abort the count; after release the channel SHALL not count until a CTRL_WR plus a complete count write.

Structure
REQ-034 Package pit_pkg SHALL hold the mode encodings (MODE_INT_TC, MODE_ONE_SHOT), the state enum (IDLE, ARMED, COUNTING), and the default WIDTH.
REQ-035 Read-back latch and byte mux SHALL live in sub-module pit_read_latch, parametrised by WIDTH.

Verification
REQ-036 WIDTH=16, mode 0, write 0x05,0x00, GATE=1, continuous TICK -> OUT=0 until CE=0; OUT=1 on the 6th TICK after completion; NULL_COUNT=1 for exactly one TICK interval.
REQ-037 Mode 0, count 10, drop GATE for 3 TICKs mid-count -> OUT rises 3 TICKs late.
REQ-038 Mode 1, count 4, GATE pulse -> OUT low for 4 TICKs; retrigger at CE=2 -> OUT low for 4 more TICKs, 6 total.
REQ-039 Count 0x1234, LATCH at CE=0x1200, then 2 TICKs and 2 reads -> 0x00, 0x12; a 3rd read returns live CE LSB 0xFE.
REQ-040 WIDTH=8, count 0x00 -> OUT rises after 256 TICKs.
REQ-041 RST_N pulsed mid-count at CE=3 -> OUT=0 at once, no further activity until reprogrammed; CTRL_WR colliding with WR_EN -> byte discarded.
